// File: rtl/alu_pkg.sv
// Shared ALU encodings and the flag vector reported by the add/subtract pipe.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/addsub_seg.sv
// One registered carry segment: SEG_W-bit sum plus carry-out, loaded only when enabled.
module addsub_seg
  import alu_pkg::*;
#(
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_sum,
  output logic             o_cout
);

  logic [SEG_W:0] w_full;
  logic [SEG_W:0] r_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, i_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_full <= '0;
    else if (i_en) r_full <= w_full;
  end

  assign o_sum  = r_full[SEG_W-1:0];
  assign o_cout = r_full[SEG_W];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES registered segments,
// upper operand segments ride along the pipe and finished low segments are skew-delayed.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SEG_W = WIDTH / STAGES;

  logic              w_adv;
  logic [STAGES:1]   r_vld;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] w_en;

  // Index k = inputs to / registers of stage k; index 0 sources come straight from the ports.
  logic [WIDTH-1:0]  w_a_src [STAGES];
  logic [WIDTH-1:0]  w_b_src [STAGES];
  logic [WIDTH-1:0]  w_r_src [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_sub_src;

  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];
  logic [WIDTH-1:0]  r_lo    [STAGES];
  logic [STAGES-1:0] r_sub;
  logic [SEG_W-1:0]  w_sum   [STAGES];
  logic [STAGES-1:0] w_cout;
  logic [WIDTH-1:0]  w_res   [STAGES];
  logic              r_seen;
  alu_flags_t        w_flags;

  assign vld_pipe  = {r_vld, in_valid};
  assign out_valid = r_vld[STAGES];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_en      = {STAGES{w_adv}} & vld_pipe[STAGES-1:0];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_res[k] = r_lo[k];
      w_res[k][k*SEG_W +: SEG_W] = w_sum[k];
    end
  end

  always_comb begin
    w_a_src[0]   = a;
    w_b_src[0]   = (sub == ALU_OP_SUB) ? ~b : b;
    w_c_src[0]   = (sub == ALU_OP_SUB) ? ~c_in : c_in;
    w_sub_src[0] = sub;
    w_r_src[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_a_src[k]   = r_a[k-1];
      w_b_src[k]   = r_b[k-1];
      w_c_src[k]   = w_cout[k-1];
      w_sub_src[k] = r_sub[k-1];
      w_r_src[k]   = w_res[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en[k]),
      .i_a   (w_a_src[k][k*SEG_W +: SEG_W]),
      .i_b   (w_b_src[k][k*SEG_W +: SEG_W]),
      .i_cin (w_c_src[k]),
      .o_sum (w_sum[k]),
      .o_cout(w_cout[k])
    );
  end

  // Data registers load only with a valid beat, so the last result stays put once the pipe drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_sub  <= '0;
      r_seen <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_lo[k] <= '0;
      end
    end else begin
      if (w_adv)           r_vld  <= vld_pipe[STAGES-1:0];
      if (w_en[STAGES-1])  r_seen <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_a[k]   <= w_a_src[k];
          r_b[k]   <= w_b_src[k];
          r_lo[k]  <= w_r_src[k];
          r_sub[k] <= w_sub_src[k];
        end
      end
    end
  end

  assign result = w_res[STAGES-1];

  // zero is held low until the first beat lands so the cleared result does not read as zero.
  always_comb begin
    w_flags.carry_out = r_sub[STAGES-1] ? ~w_cout[STAGES-1] : w_cout[STAGES-1];
    w_flags.overflow  = (r_a[STAGES-1][WIDTH-1] ^ result[WIDTH-1]) &
                        ~(r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1]);
    w_flags.zero      = r_seen & ~|result;
    w_flags.negative  = result[WIDTH-1];
  end

  assign carry_out = w_flags.carry_out;
  assign overflow  = w_flags.overflow;
  assign zero      = w_flags.zero;
  assign negative  = w_flags.negative;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: 64/4 main instance plus 32/2 and 64/1 instances on shared stimulus.
module tb_addsub_pipe;

  localparam int NSW = 200;

  logic        clk;
  logic        rst;
  logic        in_valid, out_ready, sub, c_in;
  logic [63:0] a, b;

  logic        in_ready, out_valid, co, ovf, zr, ng;
  logic [63:0] result;
  logic        in_ready32, out_valid32, co32, ovf32, zr32, ng32;
  logic [31:0] result32;
  logic        in_ready1, out_valid1, co1, ovf1, zr1, ng1;
  logic [63:0] result1;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  logic [63:0] bp_a [8];
  logic [63:0] bp_b [8];
  logic [7:0]  bp_s, bp_c;
  logic [67:0] sbq [$];

  logic [63:0] ha [NSW];
  logic [63:0] hb [NSW];
  logic        hs [NSW];
  logic        hc [NSW];
  logic        hv [NSW];

  addsub_pipe #(.WIDTH(64), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(co), .overflow(ovf), .zero(zr), .negative(ng)
  );

  addsub_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a[31:0]), .b(b[31:0]), .sub(sub), .c_in(c_in),
    .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
    .carry_out(co32), .overflow(ovf32), .zero(zr32), .negative(ng32)
  );

  addsub_pipe #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .carry_out(co1), .overflow(ovf1), .zero(zr1), .negative(ng1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: wide arithmetic, borrow = sign of the exact difference, overflow from operand/result signs.
  function automatic logic [67:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic s, input logic ci, input int w);
    logic [63:0] m, xm, ym, r;
    logic [64:0] t;
    logic        am, bm, rm, c, ov;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xm = x & m;
    ym = y & m;
    t  = s ? ({1'b0, xm} - {1'b0, ym} - {64'd0, ci}) : ({1'b0, xm} + {1'b0, ym} + {64'd0, ci});
    r  = t[63:0] & m;
    c  = t[w];
    am = xm[w-1];
    bm = ym[w-1];
    rm = r[w-1];
    ov = s ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    return {r, c, ov, (r == 64'd0), rm};
  endfunction

  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic ts, input logic tc, input logic [63:0] er, input logic [3:0] ef);
    int lat;
    a = ta; b = tb; sub = ts; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 68'(in_ready), 68'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    #1;
    chk({tag, " latency"}, 68'(lat), 68'(4));
    chk({tag, " result"}, 68'(result), 68'(er));
    chk({tag, " flags"}, 68'({co, ovf, zr, ng}), 68'(ef));
    @(posedge clk); #1;
  endtask

  task automatic sw_chk(input string tag, input int c, input int s, input int w,
                        input logic ir, input logic ov, input logic [67:0] obs);
    int   j;
    logic ev;
    j  = c - s;
    ev = (j >= 0 && j < NSW) ? hv[j] : 1'b0;
    chk({tag, " in_ready"}, 68'(ir), 68'(1));
    chk({tag, " out_valid"}, 68'(ov), 68'(ev));
    if (ev && ov) chk({tag, " data"}, obs, model(ha[j], hb[j], hs[j], hc[j], w));
  endtask

  initial begin
    int          sent, rcv, cyc;
    logic        held_v;
    logic [67:0] held, e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    #1;
    chk("reset out_valid", 68'(out_valid), 68'(0));
    chk("reset in_ready", 68'(in_ready), 68'(1));
    chk("reset outputs", {result, co, ovf, zr, ng}, 68'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-release outputs", {result, co, ovf, zr, ng}, 68'(0));
    @(posedge clk); #1;

    // flags order: {carry_out, overflow, zero, negative}
    run_op("sub neg",      64'd738468, 64'd900000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFD_8904, 4'b1001);
    run_op("sub pos",      64'd7446525, 64'd1000000, 1'b1, 1'b0, 64'd6446525, 4'b0000);
    run_op("sub ovf",      64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100);
    run_op("add wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 4'b1010);
    run_op("add ovf",      64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b0101);
    run_op("sub borrowin", 64'd5, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001);
    run_op("add segcarry", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 4'b0000);
    run_op("sub zero",     64'h1234, 64'h1234, 1'b1, 1'b0, 64'd0, 4'b0010);

    // Backpressure: 8 ops back-to-back, out_ready low for the first 10 cycles.
    bp_a = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 64'h10, 64'h7FFF_FFFF_FFFF_FFFF,
             64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000, 64'h5555_5555_5555_5555,
             64'h0F0F_0F0F_0F0F_0F0F};
    bp_b = '{64'h1111_1111_1111_1111, 64'h0000_0001_0000_0000, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h1, 64'h8000_0000_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0101_0101_0101_0101};
    bp_s = 8'b0001_1100;
    bp_c = 8'b0101_0000;
    sent = 0; rcv = 0; cyc = 0; held_v = 1'b0; held = '0;
    while (rcv < 8 && cyc < 60) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = bp_a[sent]; b = bp_b[sent]; sub = bp_s[sent]; c_in = bp_c[sent];
      end
      out_ready = (cyc >= 10);
      #1;
      chk("bp in_ready", 68'(in_ready), 68'((cyc < 4) || (cyc >= 10)));
      if (held_v) chk("bp stall hold", {result, co, ovf, zr, ng}, held);
      held_v = out_valid && !out_ready;
      held   = {result, co, ovf, zr, ng};
      if (in_valid && in_ready) begin
        sbq.push_back(model(a, b, sub, c_in, 64));
        sent++;
      end
      if (out_valid && out_ready) begin
        e = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        chk("bp order", {result, co, ovf, zr, ng}, e);
        rcv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp count", 68'(rcv), 68'(8));

    // Reset with three ops in flight: cleared at once, nothing emitted afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 64'h100 + 64'(i); b = 64'h3; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst out_valid", 68'(out_valid), 68'(0));
    chk("rst outputs", {result, co, ovf, zr, ng}, 68'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rst no emit", 68'(out_valid), 68'(0));
      @(posedge clk); #1;
    end

    // Streaming sweep on all three instances, out_ready held high.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < NSW + 5; c++) begin
      if (c < NSW) begin
        ha[c] = {$urandom, $urandom};
        hb[c] = ($urandom_range(0, 7) == 0) ? ha[c] : {$urandom, $urandom};
        hs[c] = 1'($urandom_range(0, 1));
        hc[c] = 1'($urandom_range(0, 1));
        hv[c] = ($urandom_range(0, 3) != 0);
        a = ha[c]; b = hb[c]; sub = hs[c]; c_in = hc[c]; in_valid = hv[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      sw_chk("sw 64/4", c, 4, 64, in_ready,   out_valid,   {result, co, ovf, zr, ng});
      sw_chk("sw 32/2", c, 2, 32, in_ready32, out_valid32, {32'd0, result32, co32, ovf32, zr32, ng32});
      sw_chk("sw 64/1", c, 1, 64, in_ready1,  out_valid1,  {result1, co1, ovf1, zr1, ng1});
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
